pipe_tracker: RTL
=================

PIPE_TRACKER -- requirements
Module: pipe_tracker

Interface
REQ-001 Parameter DEPTH, default 5: number of tracked pipeline stages (stage 0 = IF, stage DEPTH-1 = WB); legal range 2..16.
REQ-002 Parameter XLEN, default 32: width of instruction word and PC.
REQ-003 Parameter CNT_W, default 32: width of retire counter.
REQ-004 Parameter SENTINEL, default 32'hdeadbeef: end-of-program instruction word.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-007 fetch_valid  input  1  new instruction offered to stage 0.
REQ-008 fetch_inst  input  XLEN  offered instruction word.
REQ-009 fetch_pc  input  XLEN  PC of offered instruction.
REQ-010 fetch_ready  output  1  tracker accepts offer this cycle.
REQ-011 stall  input  DEPTH  per-stage hold request from CPU.
REQ-012 flush  input  DEPTH  flush[k] kills stages 0..k.
REQ-013 stage_valid  output  DEPTH  occupancy per stage.
REQ-014 stage_inst  output  DEPTH*XLEN  flattened stage words, stage k at bits [k*XLEN +: XLEN].
REQ-015 retire_valid  output  1  one-cycle pulse, instruction left last stage.
REQ-016 retire_inst, retire_pc  output  XLEN each  retired instruction and PC.
REQ-017 retire_count  output  CNT_W  total retirements since reset.
REQ-018 done  output  1  sticky, SENTINEL retired.

Function
REQ-019 Per-stage state: valid bit, inst, pc; inst/pc of invalid stages are don't-care but SHALL be zeroed on reset and on flush.
REQ-020 Combinational hold: hold[DEPTH-1]=stall[DEPTH-1]; hold[k]=stall[k] | hold[k+1] for k<DEPTH-1.
REQ-021 fetch_ready SHALL equal !hold[0] & !done & (flush==0).
REQ-022 Accept: fetch_valid & fetch_ready loads stage 0 with valid=1 at posedge; fetch_valid & !fetch_ready is ignored (no buffering).
REQ-023 Stage 0 with !hold[0] and no accept SHALL become invalid (bubble).
REQ-024 Advance: for k>=1, if !hold[k], stage k loads stage k-1 contents; if hold[k-1] & !hold[k], stage k becomes a bubble.
REQ-025 Held stage (hold[k]=1) keeps its contents unchanged.
REQ-026 Retire: at posedge, if stage_valid[DEPTH-1] & !hold[DEPTH-1], retire_valid<=1 with retire_inst/retire_pc<=stage DEPTH-1 contents; else retire_valid<=0, retire_inst/pc hold last value.
REQ-027 Latency: with no stalls/flushes, instruction accepted at edge t produces retire_valid=1 in the cycle after edge t+DEPTH.
REQ-028 Flush: if any flush bit set, let m = highest set index; stages 0..m SHALL become invalid at posedge, overriding hold and advance; stages above m advance/hold normally (stage m+1 receives bubble).
REQ-029 flush[DEPTH-1] SHALL suppress retirement in that cycle.
REQ-030 retire_count increments by 1 per retirement, saturating at all-ones (no wrap).
REQ-031 done sets at posedge when retiring word equals SENTINEL; remains 1 until reset; after done, no further accepts, pipeline continues draining and retiring.
REQ-032 Stall and flush on the same stage in the same cycle: flush wins.

Reset
REQ-033 rst=0 SHALL asynchronously clear all stage_valid, stage_inst, pc, retire_valid, retire_inst, retire_pc, retire_count, done to 0.
REQ-034 Reset mid-operation discards in-flight instructions; no retire pulse is produced for them.
REQ-035 First accept possible on first posedge after rst rises; fetch_ready=1 during reset-exit cycle if stall/flush are 0.

Verification
REQ-036 DEPTH=5, no stalls, issue 00000013, 00402283, 00000013 on consecutive cycles -> retire_valid high for 3 consecutive cycles starting 5 edges after first accept, in order, retire_count=3.
REQ-037 stall[2]=1 for 2 cycles with pipeline full -> stages 0..2 hold, fetch_ready=0, stage 3 receives two bubbles, retire order unchanged, no duplicates.
REQ-038 flush[1]=1 for one cycle with stages 0..4 valid -> stages 0,1 invalid next cycle, stage 2 bubble, only the 3 older instructions retire.
REQ-039 Issue SENTINEL 32'hdeadbeef after two instructions -> done rises with its retirement, fetch_ready stays 0 afterward, retire_count=3.
REQ-040 Assert rst=0 between clock edges with 4 instructions in flight -> all outputs 0 immediately; after release, no stale retire pulses.
REQ-041 CNT_W=2, retire 5 instructions -> retire_count saturates at 3.

Source files
------------

// File: rtl/pipe_tracker_if.sv
// Handshake and observation bundle between a CPU model and pipe_tracker.
// The CPU side drives fetch offers and per-stage stall/flush; the tracker reports occupancy and retirement.
interface pipe_tracker_if #(
    parameter int DEPTH = 5,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic                    fetch_valid;
    logic [XLEN-1:0]         fetch_inst;
    logic [XLEN-1:0]         fetch_pc;
    logic                    fetch_ready;
    logic [DEPTH-1:0]        stall;
    logic [DEPTH-1:0]        flush;
    logic [DEPTH-1:0]        stage_valid;
    logic [DEPTH*XLEN-1:0]   stage_inst;
    logic                    retire_valid;
    logic [XLEN-1:0]         retire_inst;
    logic [XLEN-1:0]         retire_pc;
    logic [CNT_W-1:0]        retire_count;
    logic                    done;

    modport master (
        output fetch_valid, fetch_inst, fetch_pc, stall, flush,
        input  fetch_ready, stage_valid, stage_inst,
        input  retire_valid, retire_inst, retire_pc, retire_count, done
    );

    modport slave (
        input  fetch_valid, fetch_inst, fetch_pc, stall, flush,
        output fetch_ready, stage_valid, stage_inst,
        output retire_valid, retire_inst, retire_pc, retire_count, done
    );
endinterface

// File: rtl/pipe_tracker.sv
// Shadow model of an in-order CPU pipeline: tracks per-stage occupancy under stall/flush,
// reports retirements, counts them (saturating) and latches done when the sentinel retires.
module pipe_tracker #(
    parameter int              DEPTH    = 5,
    parameter int              XLEN     = 32,
    parameter int              CNT_W    = 32,
    parameter logic [XLEN-1:0] SENTINEL = XLEN'(32'hdeadbeef)
) (
    input  logic          clk,
    input  logic          rst,
    pipe_tracker_if.slave bus
);

    logic [DEPTH-1:0] valid_q;
    logic [XLEN-1:0]  inst_q [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];

    logic             retire_valid_q;
    logic [XLEN-1:0]  retire_inst_q;
    logic [XLEN-1:0]  retire_pc_q;
    logic [CNT_W-1:0] retire_count_q;
    logic             done_q;

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] kill;
    logic             flush_any;
    logic             ready;
    logic             accept;
    logic             fire;

    // hold propagates backwards from a stalled stage; kill[k] is set when any flush
    // bit at index >= k is set, i.e. stage k lies at or below the highest flush index.
    always_comb begin
        logic acc_h;
        logic acc_k;
        hold  = '0;
        kill  = '0;
        acc_h = 1'b0;
        acc_k = 1'b0;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            acc_h = acc_h | bus.stall[DEPTH-i];
            acc_k = acc_k | bus.flush[DEPTH-i];
            hold[DEPTH-i] = acc_h;
            kill[DEPTH-i] = acc_k;
        end
    end

    assign flush_any = |bus.flush;
    assign ready     = ~hold[0] & ~done_q & ~flush_any;
    assign accept    = bus.fetch_valid & ready;
    assign fire      = valid_q[DEPTH-1] & ~hold[DEPTH-1] & ~kill[DEPTH-1];

    // Stage 0: fetch entry point
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q[0] <= 1'b0;
            inst_q[0]  <= '0;
            pc_q[0]    <= '0;
        end else if (kill[0]) begin
            valid_q[0] <= 1'b0;
            inst_q[0]  <= '0;
            pc_q[0]    <= '0;
        end else if (!hold[0]) begin
            valid_q[0] <= accept;
            if (accept) begin
                inst_q[0] <= bus.fetch_inst;
                pc_q[0]   <= bus.fetch_pc;
            end
        end
    end

    // Stages 1..DEPTH-1: a held or killed predecessor hands on a bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                inst_q[k]  <= '0;
                pc_q[k]    <= '0;
            end
        end else begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (kill[k]) begin
                    valid_q[k] <= 1'b0;
                    inst_q[k]  <= '0;
                    pc_q[k]    <= '0;
                end else if (!hold[k]) begin
                    valid_q[k] <= valid_q[k-1] & ~hold[k-1] & ~kill[k-1];
                    inst_q[k]  <= inst_q[k-1];
                    pc_q[k]    <= pc_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_valid_q <= 1'b0;
            retire_inst_q  <= '0;
            retire_pc_q    <= '0;
            retire_count_q <= '0;
            done_q         <= 1'b0;
        end else begin
            retire_valid_q <= fire;
            if (fire) begin
                retire_inst_q <= inst_q[DEPTH-1];
                retire_pc_q   <= pc_q[DEPTH-1];
                if (retire_count_q != '1) begin
                    retire_count_q <= retire_count_q + 1'b1;
                end
                if (inst_q[DEPTH-1] == SENTINEL) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.stage_inst = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            bus.stage_inst[k*XLEN +: XLEN] = inst_q[k];
        end
    end

    assign bus.fetch_ready  = ready;
    assign bus.stage_valid  = valid_q;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_inst  = retire_inst_q;
    assign bus.retire_pc    = retire_pc_q;
    assign bus.retire_count = retire_count_q;
    assign bus.done         = done_q;

endmodule
